// File: rtl/ins_fetch.sv
// Instruction fetch stage: PC, single-outstanding memory request, one-entry skid
// buffer for stalled acks, and the IF/ID pipeline register feeding decode.
module ins_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [31:0] iBranchTarget,
    output logic        oImemReq,
    output logic [31:0] oImemAddr,
    input  logic        iImemAck,
    input  logic [31:0] iImemData,
    output logic [31:0] oins,
    output logic [31:0] oPCPlus4,
    output logic        oValid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        BUF   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] buf_ins_q, buf_ins_d;
    logic [31:0] buf_pcp4_q, buf_pcp4_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_pc;
    logic        fetch_ack;

    assign pc_plus4  = pc_q + 32'd4;
    assign branch_pc = {iBranchTarget[31:2], 2'b00};
    assign fetch_ack = (state_q == FETCH) && iImemAck;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (iBranchTaken) begin
                    state_d = iImemAck ? FETCH : DRAIN;
                end else if (iImemAck && iStall) begin
                    state_d = BUF;
                end
            end
            BUF: begin
                if (iBranchTaken || !iStall) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (iImemAck) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs to instruction memory
    // ------------------------------------------------------------------
    // DRAIN keeps presenting the abandoned address until its ack retires it.
    always_comb begin
        oImemReq  = 1'b0;
        oImemAddr = pc_q;
        unique case (state_q)
            FETCH: oImemReq = !rstn;
            BUF:   oImemReq = 1'b0;
            DRAIN: begin
                oImemReq  = !rstn;
                oImemAddr = req_addr_q;
            end
            default: oImemReq = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state: PC, request address, skid buffer, IF/ID
    // ------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        buf_ins_d  = buf_ins_q;
        buf_pcp4_d = buf_pcp4_q;
        ins_d      = ins_q;
        pcp4_d     = pcp4_q;
        valid_d    = valid_q;

        if (state_q == FETCH) begin
            req_addr_d = pc_q;
        end

        if (iBranchTaken) begin
            // Redirect beats stall; any ack data this cycle is wrong-path.
            pc_d       = branch_pc;
            valid_d    = 1'b0;
            buf_ins_d  = 32'h0;
            buf_pcp4_d = 32'h0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (iImemAck) begin
                        pc_d = pc_plus4;
                        if (iStall) begin
                            buf_ins_d  = iImemData;
                            buf_pcp4_d = pc_plus4;
                        end else begin
                            ins_d   = iImemData;
                            pcp4_d  = pc_plus4;
                            valid_d = 1'b1;
                        end
                    end else if (!iStall) begin
                        valid_d = 1'b0;
                    end
                end
                BUF: begin
                    if (!iStall) begin
                        ins_d   = buf_ins_q;
                        pcp4_d  = buf_pcp4_q;
                        valid_d = 1'b1;
                    end
                end
                DRAIN: begin
                    // Ack here retires the abandoned request; its data is dropped.
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_ins_q  <= 32'h0;
            buf_pcp4_q <= 32'h0;
            ins_q      <= 32'h0;
            pcp4_q     <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            buf_ins_q  <= buf_ins_d;
            buf_pcp4_q <= buf_pcp4_d;
            ins_q      <= ins_d;
            pcp4_q     <= pcp4_d;
            valid_q    <= valid_d;
        end
    end

    assign oins     = ins_q;
    assign oPCPlus4 = pcp4_q;
    assign oValid   = valid_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed, table-driven bench for ins_fetch: each row drives one cycle of
// inputs and checks the outputs seen before that cycle's rising edge.
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        iStall;
    logic        iBranchTaken;
    logic [31:0] iBranchTarget;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemAck;
    logic [31:0] iImemData;
    logic [31:0] oins;
    logic [31:0] oPCPlus4;
    logic        oValid;

    // Second instance exercising the PC wrap at the top of the address space.
    logic        rst2;
    logic        ack2;
    logic [31:0] data2;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] ins2;
    logic [31:0] pcp4_2;
    logic        valid2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ins_fetch dut (
        .clk          (clk),
        .rstn         (rstn),
        .iStall       (iStall),
        .iBranchTaken (iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .oImemReq     (oImemReq),
        .oImemAddr    (oImemAddr),
        .iImemAck     (iImemAck),
        .iImemData    (iImemData),
        .oins         (oins),
        .oPCPlus4     (oPCPlus4),
        .oValid       (oValid)
    );

    ins_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk          (clk),
        .rstn         (rst2),
        .iStall       (1'b0),
        .iBranchTaken (1'b0),
        .iBranchTarget(32'h0),
        .oImemReq     (req2),
        .oImemAddr    (addr2),
        .iImemAck     (ack2),
        .iImemData    (data2),
        .oins         (ins2),
        .oPCPlus4     (pcp4_2),
        .oValid       (valid2)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ins;
        logic [31:0] e_pcp4;
    } vec_t;

    vec_t vecs[28];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {8'h13, a[23:0]};
    endfunction

    function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                                input logic [31:0] tgt, input logic ack,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_ins,
                                input logic [31:0] e_pcp4);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt; v.ack = ack;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_ins = e_ins; v.e_pcp4 = e_pcp4;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //            rst stall br tgt           ack | req addr          v  ins              pc+4
        vecs[0]  = mk(1, 0, 0, 32'h0,    0,  0, 32'h0,     0, 32'h0,        32'h0);
        // zero-wait streaming, four instructions back to back
        vecs[1]  = mk(0, 0, 0, 32'h0,    1,  1, 32'h0,     0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 0, 0, 32'h0,    1,  1, 32'h4,     1, memf(32'h0),  32'h4);
        vecs[3]  = mk(0, 0, 0, 32'h0,    1,  1, 32'h8,     1, memf(32'h4),  32'h8);
        vecs[4]  = mk(0, 0, 0, 32'h0,    1,  1, 32'hC,     1, memf(32'h8),  32'hC);
        // memory wait without stall produces a bubble, data held
        vecs[5]  = mk(0, 0, 0, 32'h0,    0,  1, 32'h10,    1, memf(32'hC),  32'h10);
        vecs[6]  = mk(0, 0, 0, 32'h0,    1,  1, 32'h10,    0, memf(32'hC),  32'h10);
        // ack under stall goes to skid buffer; no request while buffered
        vecs[7]  = mk(0, 1, 0, 32'h0,    1,  1, 32'h14,    1, memf(32'h10), 32'h14);
        vecs[8]  = mk(0, 1, 0, 32'h0,    1,  0, 32'h18,    1, memf(32'h10), 32'h14);
        vecs[9]  = mk(0, 1, 0, 32'h0,    0,  0, 32'h18,    1, memf(32'h10), 32'h14);
        vecs[10] = mk(0, 0, 0, 32'h0,    0,  0, 32'h18,    1, memf(32'h10), 32'h14);
        vecs[11] = mk(0, 0, 0, 32'h0,    0,  1, 32'h18,    1, memf(32'h14), 32'h18);
        vecs[12] = mk(0, 0, 0, 32'h0,    1,  1, 32'h18,    0, memf(32'h14), 32'h18);
        // branch + stall + ack with valid IF/ID; target low bits dropped
        vecs[13] = mk(0, 1, 1, 32'h203,  1,  1, 32'h1C,    1, memf(32'h18), 32'h1C);
        // branch in first wait cycle: old address held until ack, data dropped
        vecs[14] = mk(0, 0, 1, 32'h100,  0,  1, 32'h200,   0, memf(32'h18), 32'h1C);
        vecs[15] = mk(0, 0, 0, 32'h0,    0,  1, 32'h200,   0, memf(32'h18), 32'h1C);
        vecs[16] = mk(0, 0, 0, 32'h0,    0,  1, 32'h200,   0, memf(32'h18), 32'h1C);
        vecs[17] = mk(0, 0, 0, 32'h0,    1,  1, 32'h200,   0, memf(32'h18), 32'h1C);
        vecs[18] = mk(0, 0, 0, 32'h0,    1,  1, 32'h100,   0, memf(32'h18), 32'h1C);
        // two branches while draining: the latest target wins
        vecs[19] = mk(0, 0, 1, 32'h300,  0,  1, 32'h104,   1, memf(32'h100),32'h104);
        vecs[20] = mk(0, 0, 1, 32'h400,  0,  1, 32'h104,   0, memf(32'h100),32'h104);
        // reset while draining; late ack during reset ignored
        vecs[21] = mk(1, 0, 0, 32'h0,    0,  0, 32'h104,   0, memf(32'h100),32'h104);
        vecs[22] = mk(1, 0, 0, 32'h0,    1,  0, 32'h0,     0, 32'h0,        32'h0);
        vecs[23] = mk(0, 0, 0, 32'h0,    1,  1, 32'h0,     0, 32'h0,        32'h0);
        // branch out of BUF returns to FETCH; buffered instruction discarded
        vecs[24] = mk(0, 1, 0, 32'h0,    1,  1, 32'h4,     1, memf(32'h0),  32'h4);
        vecs[25] = mk(0, 1, 1, 32'h500,  1,  0, 32'h8,     1, memf(32'h0),  32'h4);
        vecs[26] = mk(0, 0, 0, 32'h0,    0,  1, 32'h500,   0, memf(32'h0),  32'h4);
        vecs[27] = mk(0, 0, 0, 32'h0,    0,  1, 32'h500,   0, memf(32'h0),  32'h4);

        rstn = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 32'h0;
        iImemAck = 1'b0; iImemData = 32'h0;
        rst2 = 1'b1; ack2 = 1'b0; data2 = 32'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            rstn          = vecs[i].rst;
            iStall        = vecs[i].stall;
            iBranchTaken  = vecs[i].br;
            iBranchTarget = vecs[i].tgt;
            iImemAck      = vecs[i].ack;
            iImemData     = vecs[i].ack ? memf(vecs[i].e_addr) : 32'hDEAD_BEEF;
            #1;
            check($sformatf("row%0d req", i),   {31'h0, oImemReq}, {31'h0, vecs[i].e_req});
            check($sformatf("row%0d addr", i),  oImemAddr,         vecs[i].e_addr);
            check($sformatf("row%0d valid", i), {31'h0, oValid},   {31'h0, vecs[i].e_valid});
            check($sformatf("row%0d ins", i),   oins,              vecs[i].e_ins);
            check($sformatf("row%0d pcp4", i),  oPCPlus4,          vecs[i].e_pcp4);
        end

        // Wrap-around instance: first fetch at FFFF_FFFC, PC+4 wraps to 0.
        @(negedge clk);
        iImemAck = 1'b0;
        check("wrap reset req",   {31'h0, req2},   32'h0);
        check("wrap reset valid", {31'h0, valid2}, 32'h0);
        rst2  = 1'b0;
        ack2  = 1'b1;
        data2 = memf(32'hFFFF_FFFC);
        #1;
        check("wrap first req",  {31'h0, req2}, 32'h1);
        check("wrap first addr", addr2,         32'hFFFF_FFFC);
        @(negedge clk);
        ack2 = 1'b0;
        #1;
        check("wrap valid",       {31'h0, valid2}, 32'h1);
        check("wrap ins",         ins2,            memf(32'hFFFF_FFFC));
        check("wrap pcp4",        pcp4_2,          32'h0);
        check("wrap second addr", addr2,           32'h0);
        check("wrap second req",  {31'h0, req2},   32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
